// File: rtl/segajoy_filter_if.sv
// Decoded pad bus between the joystick scanner (master) and the debounce/autofire filter (slave).
interface segajoy_filter_if;
    logic       joy_stb;
    logic [7:0] joy_in;
    logic       af_en;
    logic [7:0] joy_out;
    logic       joy_chg;

    modport master (
        output joy_stb,
        output joy_in,
        output af_en,
        input  joy_out,
        input  joy_chg
    );

    modport slave (
        input  joy_stb,
        input  joy_in,
        input  af_en,
        output joy_out,
        output joy_chg
    );
endinterface

// File: rtl/segajoy_filter.sv
// Per-scan debounce plus optional autofire for decoded Sega/Atari pad bits.
// Autofire is built only when SEGAJOY_FILTER_AUTOFIRE_EN is defined.
module segajoy_filter #(
    parameter int         DEBOUNCE  = 3,
    parameter int         AF_PERIOD = 3,
    parameter logic [7:0] AF_MASK   = 8'h70
) (
    input  logic            clk115200,
    input  logic            rst_n,
    segajoy_filter_if.slave bus
);
    localparam logic [2:0] DB_LAST = 3'(DEBOUNCE - 1);

    logic [7:0] db_q, db_d;
    logic [2:0] db_cnt_q [8];
    logic [2:0] db_cnt_d [8];
    logic [7:0] bit_diff;
    logic [7:0] bit_hit;
    logic [7:0] joy_out_q, joy_out_d;
    logic       joy_chg_q, joy_chg_d;

    // Each bit flips only after DEBOUNCE consecutive disagreeing scans.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_db
            assign bit_diff[gi] = bus.joy_in[gi] ^ db_q[gi];
            assign bit_hit[gi]  = bit_diff[gi] && (db_cnt_q[gi] == DB_LAST);
            assign db_d[gi]     = bit_hit[gi] ? bus.joy_in[gi] : db_q[gi];
            assign db_cnt_d[gi] = (!bit_diff[gi] || bit_hit[gi]) ? 3'd0
                                                                  : db_cnt_q[gi] + 3'd1;

            always_ff @(posedge clk115200 or negedge rst_n) begin
                if (!rst_n) begin
                    db_cnt_q[gi] <= 3'd0;
                end else if (bus.joy_stb) begin
                    db_cnt_q[gi] <= db_cnt_d[gi];
                end
            end
        end
    endgenerate

`ifdef SEGAJOY_FILTER_AUTOFIRE_EN
    localparam logic [3:0] AF_LAST = 4'(AF_PERIOD - 1);

    logic [3:0] af_cnt_q, af_cnt_d;
    logic       af_phase_q, af_phase_d;

    // One shared phase for all masked bits; it idles high so a fresh press fires at once.
    always_comb begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (((db_d & AF_MASK) == 8'h00) || !bus.af_en) begin
            af_cnt_d   = 4'd0;
            af_phase_d = 1'b1;
        end else if (af_cnt_q == AF_LAST) begin
            af_cnt_d   = 4'd0;
            af_phase_d = ~af_phase_q;
        end else begin
            af_cnt_d   = af_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk115200 or negedge rst_n) begin
        if (!rst_n) begin
            af_cnt_q   <= 4'd0;
            af_phase_q <= 1'b1;
        end else if (bus.joy_stb) begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end

    assign joy_out_d = (db_d & ~AF_MASK) | (db_d & AF_MASK & {8{af_phase_d}});
`else
    logic unused_af_en;
    assign unused_af_en = bus.af_en;
    assign joy_out_d    = db_d;
`endif

    assign joy_chg_d = bus.joy_stb && (joy_out_d != joy_out_q);

    always_ff @(posedge clk115200 or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 8'h00;
            joy_out_q <= 8'h00;
            joy_chg_q <= 1'b0;
        end else begin
            joy_chg_q <= joy_chg_d;
            if (bus.joy_stb) begin
                db_q      <= db_d;
                joy_out_q <= joy_out_d;
            end
        end
    end

    assign bus.joy_out = joy_out_q;
    assign bus.joy_chg = joy_chg_q;
endmodule
